// File: rtl/hash_msg_loader.sv
// Byte-wide message loader for the serial Ascon hashing wrapper.
// Collects a Y-bit message, pulses the wrapper reset, streams the message
// MSB-first one bit per clock, then raises start until the core is ready.
module hash_msg_loader #(
  parameter int Y = 32,
  parameter int L = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_dataxSI,
  input  logic       in_validxSI,
  output logic       in_readyxSO,
  output logic       hash_rstxSO,
  output logic       msg_bitxSO,
  output logic       startxSO,
  input  logic       hash_readyxSI,
  output logic       busyxSO,
  output logic       donexSO
);

  // Start threshold: the wrapper is ready once its counter passes max(Y, L, 64).
  localparam int M_YL = (Y > L) ? Y : L;
  localparam int M    = (M_YL > 64) ? M_YL : 64;
  localparam int CW   = $clog2(M + 2);
  localparam int NB   = Y / 8;
  localparam int BCW  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_HRST,
    S_SHIFT,
    S_WAIT,
    S_START,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [Y-1:0]     r_buf;
  logic [Y-1:0]     w_buf_shift;
  logic [CW-1:0]    r_cnt;
  logic [BCW-1:0]   r_byte_cnt;
  logic             r_msg_bit;
  logic             r_done;
  logic             w_xfer;
  logic             w_last_byte;

  assign w_xfer      = (r_state == S_LOAD) && in_validxSI && !rst;
  assign w_last_byte = (r_byte_cnt == BCW'(NB - 1));

  // New byte enters at the bottom so the first byte ends up most significant.
  generate
    if (Y > 8) begin : g_wide
      assign w_buf_shift = {r_buf[Y-9:0], in_dataxSI};
    end else begin : g_narrow
      assign w_buf_shift = in_dataxSI;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded outputs; reset forces the safe values.
  always_comb begin
    w_state_next = r_state;
    in_readyxSO  = 1'b0;
    hash_rstxSO  = rst;
    startxSO     = 1'b0;
    busyxSO      = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_readyxSO = !rst;
        if (w_xfer && w_last_byte) w_state_next = S_HRST;
      end
      S_HRST: begin
        hash_rstxSO  = 1'b1;
        busyxSO      = !rst;
        w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        busyxSO = !rst;
        if (r_cnt == CW'(Y - 1)) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        busyxSO = !rst;
        // Counter steps to M+1 on this edge, which is where start must rise.
        if (r_cnt == CW'(M)) w_state_next = S_START;
      end
      S_START: begin
        busyxSO  = !rst;
        startxSO = !rst;
        if (hash_readyxSI) w_state_next = S_DONE;
      end
      S_DONE: begin
        busyxSO      = !rst;
        w_state_next = S_LOAD;
      end
      default: w_state_next = S_LOAD;
    endcase
  end

  // Datapath: message buffer, byte/bit counters, registered serial bit and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= '0;
      r_cnt      <= '0;
      r_byte_cnt <= '0;
      r_msg_bit  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done    <= (r_state == S_START) && hash_readyxSI;
      r_msg_bit <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            r_buf      <= w_buf_shift;
            r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
          end
        end
        S_HRST: begin
          // Pre-load the MSB so it is on the wire in the first cycle after the reset pulse.
          r_cnt     <= '0;
          r_msg_bit <= r_buf[Y-1];
          r_buf     <= r_buf << 1;
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt != CW'(Y - 1)) r_msg_bit <= r_buf[Y-1];
          r_buf <= r_buf << 1;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_START: begin
          // Counter holds at M+1 so a long ready latency cannot wrap it.
          r_cnt <= r_cnt;
        end
        S_DONE: begin
          r_buf      <= '0;
          r_byte_cnt <= '0;
          r_cnt      <= '0;
        end
        default: begin
          r_buf <= '0;
        end
      endcase
    end
  end

  assign msg_bitxSO = r_msg_bit;
  assign donexSO    = r_done;

endmodule

// File: tb/tb_hash_msg_loader.sv
// Directed testbench for hash_msg_loader (Y=32/L=256 and Y=8/L=64 instances).
module tb_hash_msg_loader;

  logic       clk;
  logic       rst;
  logic [7:0] din_a;
  logic       vld_a, rdy_a, hrst_a, mbit_a, start_a, hrdy_a, busy_a, done_a;
  logic [7:0] din_b;
  logic       vld_b, rdy_b, hrst_b, mbit_b, start_b, hrdy_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  int acc_a  = 0;

  hash_msg_loader #(.Y(32), .L(256)) dut_a (
    .clk(clk), .rst(rst),
    .in_dataxSI(din_a), .in_validxSI(vld_a), .in_readyxSO(rdy_a),
    .hash_rstxSO(hrst_a), .msg_bitxSO(mbit_a), .startxSO(start_a),
    .hash_readyxSI(hrdy_a), .busyxSO(busy_a), .donexSO(done_a)
  );

  hash_msg_loader #(.Y(8), .L(64)) dut_b (
    .clk(clk), .rst(rst),
    .in_dataxSI(din_b), .in_validxSI(vld_b), .in_readyxSO(rdy_b),
    .hash_rstxSO(hrst_b), .msg_bitxSO(mbit_b), .startxSO(start_b),
    .hash_readyxSI(hrdy_b), .busyxSO(busy_b), .donexSO(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next sampling point, counting a byte handshake on dut_a.
  task automatic tick();
    if (vld_a && rdy_a) acc_a++;
    @(negedge clk);
  endtask

  // Offer four bytes MSB-first with valid held high.
  task automatic load4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("load_rdy%0d", i), rdy_a, 1);
      din_a = w[31-8*i -: 8];
      vld_a = 1'b1;
      tick();
    end
  endtask

  // Entered at the HRST sampling point; checks the stream, start timing and done pulse.
  task automatic run(input logic [31:0] exp, input int hold, input string tag);
    int k;
    int bad;
    bad = 0;
    chk({tag, "_hrst"}, hrst_a, 1);
    chk({tag, "_hrst_busy"}, busy_a, 1);
    chk({tag, "_hrst_rdy"}, rdy_a, 0);
    hrdy_a = 1'b0;
    tick();
    chk({tag, "_hrst_fall"}, hrst_a, 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), mbit_a, exp[31-i]);
      if (rdy_a !== 1'b0) bad++;
      tick();
    end
    chk({tag, "_bit_after"}, mbit_a, 0);
    k = 32;
    while (start_a !== 1'b1 && k < 400) begin
      if (rdy_a !== 1'b0 || mbit_a !== 1'b0) bad++;
      tick();
      k++;
    end
    chk({tag, "_start_cycle"}, k, 257);
    for (int i = 0; i < hold; i++) begin
      if (start_a !== 1'b1 || rdy_a !== 1'b0 || done_a !== 1'b0) bad++;
      tick();
    end
    chk({tag, "_start_held"}, start_a, 1);
    hrdy_a = 1'b1;
    tick();
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_done_start"}, start_a, 0);
    chk({tag, "_done_busy"}, busy_a, 1);
    chk({tag, "_done_rdy"}, rdy_a, 0);
    hrdy_a = 1'b0;
    tick();
    chk({tag, "_post_done"}, done_a, 0);
    chk({tag, "_post_busy"}, busy_a, 0);
    chk({tag, "_post_rdy"}, rdy_a, 1);
    chk({tag, "_bad_cycles"}, bad, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    din_a = 8'h00; vld_a = 1'b0; hrdy_a = 1'b0;
    din_b = 8'h00; vld_b = 1'b0; hrdy_b = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_rdy", rdy_a, 0);
    chk("rst_hrst", hrst_a, 1);
    chk("rst_mbit", mbit_a, 0);
    chk("rst_start", start_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", rdy_a, 1);
    chk("post_rst_hrst", hrst_a, 0);
    $display("step: reset checked");

    // Basic run with a long ready latency
    load4(32'hDEADBEEF);
    vld_a = 1'b0;
    run(32'hDEADBEEF, 300, "basic");
    $display("step: basic run DEADBEEF with 300-cycle ready latency");

    // Valid gaps 1,0,0,1,...
    acc_a = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("gap_rdy%0d", i), rdy_a, 1);
      din_a = (i == 0) ? 8'hDE : (i == 1) ? 8'hAD : (i == 2) ? 8'hBE : 8'hEF;
      vld_a = 1'b1;
      tick();
      vld_a = 1'b0;
      din_a = 8'hFF;
      if (i < 3) begin
        chk($sformatf("gap_hold%0d", i), hrst_a, 0);
        tick();
        chk($sformatf("gap_rdy_idle%0d", i), rdy_a, 1);
        tick();
      end
    end
    chk("gap_acc", acc_a, 4);
    run(32'hDEADBEEF, 0, "gap");
    $display("step: valid-gap run");

    // Busy backpressure: valid held with 0x55 across the whole run
    acc_a = 0;
    din_a = 8'h55;
    vld_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_rdy%0d", i), rdy_a, 1);
      tick();
    end
    run(32'h55555555, 0, "bp");
    chk("bp_acc", acc_a, 4);
    vld_a = 1'b0;
    tick();
    $display("step: backpressure run, accepted %0d bytes", acc_a);

    // Reset in the middle of SHIFT at cnt=10
    load4(32'h12345678);
    vld_a = 1'b0;
    chk("mid_hrst", hrst_a, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("mid_bit%0d", i), mbit_a, (32'h12345678 >> (31 - i)) & 1);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_hrst", hrst_a, 1);
    chk("mid_rst_rdy", rdy_a, 0);
    chk("mid_rst_mbit", mbit_a, 0);
    chk("mid_rst_start", start_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    rst = 1'b0;
    tick();
    chk("mid_after_rdy", rdy_a, 1);
    chk("mid_after_busy", busy_a, 0);
    chk("mid_after_hrst", hrst_a, 0);
    load4(32'hA55AC33C);
    vld_a = 1'b0;
    run(32'hA55AC33C, 0, "mid");
    $display("step: reset mid-SHIFT then fresh run A55AC33C");

    // Y=8, L=64 instance; ready held high everywhere to show it is ignored outside START
    hrdy_b = 1'b1;
    chk("y8_rdy", rdy_b, 1);
    din_b = 8'h80;
    vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    chk("y8_hrst", hrst_b, 1);
    chk("y8_rdy_busy", rdy_b, 0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("y8_bit%0d", i), mbit_b, (i == 0) ? 1 : 0);
      @(negedge clk);
    end
    k = 8;
    while (start_b !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("y8_start_cycle", k, 65);
    @(negedge clk);
    chk("y8_done", done_b, 1);
    chk("y8_done_start", start_b, 0);
    hrdy_b = 1'b0;
    @(negedge clk);
    chk("y8_post_done", done_b, 0);
    chk("y8_post_busy", busy_b, 0);
    chk("y8_post_rdy", rdy_b, 1);
    $display("step: Y=8 run with byte 80");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
